// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter and fetch sequencer for the 9-bit CPU.
// Fetches at pc, holds the instruction for execution, then advances or branches.
module pc_sequencer #(
   parameter int              PC_W      = 10,
   parameter int              INSTR_W   = 9,
   parameter logic [PC_W-1:0] RESET_VEC = '0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   output logic               imem_req,
   output logic [PC_W-1:0]    imem_addr,
   input  logic               imem_ack,
   input  logic [INSTR_W-1:0] imem_data,
   output logic [INSTR_W-1:0] instr,
   output logic               instr_valid,
   input  logic               exec_done,
   input  logic               br_take,
   input  logic [PC_W-1:0]    br_target,
   input  logic               halt,
   output logic [PC_W-1:0]    pc,
   output logic               pc_wrap,
   output logic               running
);

   localparam logic [1:0] S_IDLE  = 2'b00;
   localparam logic [1:0] S_FETCH = 2'b01;
   localparam logic [1:0] S_EXEC  = 2'b10;
   localparam logic [1:0] S_HALT  = 2'b11;

   logic [1:0]    state;
   logic [1:0]    state_nx;
   logic [PC_W:0] pc_sum;
   logic          in_fetch;
   logic          in_exec;
   logic          adv;
   logic          seq_adv;
   logic          fetch_hit;

   // One full-width adder; its carry-out is the wrap indication.
   assign pc_sum    = {1'b0, pc} + {{PC_W{1'b0}}, 1'b1};

   assign in_fetch  = (state == S_FETCH);
   assign in_exec   = (state == S_EXEC);
   assign adv       = in_exec & exec_done;
   assign seq_adv   = adv & ~br_take;
   assign fetch_hit = in_fetch & imem_ack;

   assign imem_req    = in_fetch;
   assign imem_addr   = pc;
   assign instr_valid = in_exec;
   assign running     = in_fetch | in_exec;

   // Next-state selection; control inputs only matter in their own state.
   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE:  if (start) state_nx = S_FETCH;
         S_FETCH: if (imem_ack) state_nx = S_EXEC;
         S_EXEC: begin
            if (exec_done) state_nx = halt ? S_HALT : S_FETCH;
         end
         S_HALT:  if (start) state_nx = S_FETCH;
         default: state_nx = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nx;
   end

   // Program counter: branch target or pc+1 at end of execution.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc <= RESET_VEC;
      end else if (adv) begin
         pc <= br_take ? br_target : pc_sum[PC_W-1:0];
      end
   end

   // Instruction latch, loaded only when memory acknowledges a fetch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         instr <= '0;
      else if (fetch_hit) instr <= imem_data;
   end

   // Wrap pulse: one cycle, only for a sequential advance past the top.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pc_wrap <= 1'b0;
      else        pc_wrap <= seq_adv & pc_sum[PC_W];
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed stimulus with a cycle-level reference model.
// Every cycle the DUT outputs are compared against the model.
module tb_pc_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic       imem_req;
   logic [9:0] imem_addr;
   logic       imem_ack;
   logic [8:0] imem_data;
   logic [8:0] instr;
   logic       instr_valid;
   logic       exec_done;
   logic       br_take;
   logic [9:0] br_target;
   logic       halt;
   logic [9:0] pc;
   logic       pc_wrap;
   logic       running;

   int checks = 0;
   int errors = 0;

   pc_sequencer dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_data   (imem_data),
      .instr       (instr),
      .instr_valid (instr_valid),
      .exec_done   (exec_done),
      .br_take     (br_take),
      .br_target   (br_target),
      .halt        (halt),
      .pc          (pc),
      .pc_wrap     (pc_wrap),
      .running     (running)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: mode 0=idle 1=fetching 2=executing 3=halted.
   int m_mode  = 0;
   int m_pc    = 0;
   int m_instr = 0;
   int m_wrap  = 0;

   // Advance the model on each edge, then compare all outputs.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_mode = 0; m_pc = 0; m_instr = 0; m_wrap = 0;
      end else begin
         m_wrap = 0;
         case (m_mode)
            0: if (start) m_mode = 1;
            1: if (imem_ack) begin
                  m_instr = int'(imem_data);
                  m_mode  = 2;
               end
            2: if (exec_done) begin
                  if (br_take) begin
                     m_pc = int'(br_target);
                  end else begin
                     m_wrap = (m_pc == 1023) ? 1 : 0;
                     m_pc   = (m_pc + 1) % 1024;
                  end
                  m_mode = halt ? 3 : 1;
               end
            default: if (start) m_mode = 1;
         endcase
      end
      #1;
      chk("imem_req", int'(imem_req), (m_mode == 1) ? 1 : 0);
      chk("imem_addr", int'(imem_addr), m_pc);
      chk("pc", int'(pc), m_pc);
      chk("instr", int'(instr), m_instr);
      chk("instr_valid", int'(instr_valid), (m_mode == 2) ? 1 : 0);
      chk("pc_wrap", int'(pc_wrap), m_wrap);
      chk("running", int'(running), (m_mode == 1 || m_mode == 2) ? 1 : 0);
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   // One zero-wait fetch followed by an immediate exec_done.
   task automatic instr_cycle(input logic [8:0] d, input logic br,
                              input logic [9:0] tgt, input logic hl);
      imem_ack = 1'b1; imem_data = d;
      step();
      imem_ack = 1'b0;
      exec_done = 1'b1; br_take = br; br_target = tgt; halt = hl;
      step();
      exec_done = 1'b0; br_take = 1'b0; halt = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; imem_ack = 1'b0; imem_data = '0;
      exec_done = 1'b0; br_take = 1'b0; br_target = '0; halt = 1'b0;
      step(); step();
      chk("rst pc", int'(pc), 0);
      chk("rst req", int'(imem_req), 0);
      rst_n = 1'b1;
      step();
      chk("idle running", int'(running), 0);

      // Start and sequential fetches 0,1,2.
      start = 1'b1; step(); start = 1'b0;
      chk("seq addr0", int'(imem_addr), 10'h000);
      chk("seq run", int'(running), 1);
      instr_cycle(9'h011, 1'b0, 10'h000, 1'b0);
      chk("seq addr1", int'(imem_addr), 10'h001);
      instr_cycle(9'h022, 1'b0, 10'h000, 1'b0);
      chk("seq addr2", int'(imem_addr), 10'h002);

      // Wait states at pc=0x005.
      instr_cycle(9'h033, 1'b1, 10'h005, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("ws req", int'(imem_req), 1);
         chk("ws addr", int'(imem_addr), 10'h005);
      end
      imem_ack = 1'b1; imem_data = 9'h1A5; step(); imem_ack = 1'b0;
      chk("ws instr", int'(instr), 9'h1A5);
      chk("ws valid", int'(instr_valid), 1);

      // Branch from 0x010 to 0x2F0.
      exec_done = 1'b1; br_take = 1'b1; br_target = 10'h010; step();
      exec_done = 1'b0; br_take = 1'b0;
      instr_cycle(9'h044, 1'b1, 10'h2F0, 1'b0);
      chk("br addr", int'(imem_addr), 10'h2F0);
      chk("br wrap", int'(pc_wrap), 0);

      // Wrap at 0x3FF and carries into bits 8 and 9.
      instr_cycle(9'h055, 1'b1, 10'h3FF, 1'b0);
      instr_cycle(9'h066, 1'b0, 10'h000, 1'b0);
      chk("wrap pc", int'(pc), 10'h000);
      chk("wrap pulse", int'(pc_wrap), 1);
      step();
      chk("wrap once", int'(pc_wrap), 0);
      instr_cycle(9'h077, 1'b1, 10'h0FF, 1'b0);
      instr_cycle(9'h088, 1'b0, 10'h000, 1'b0);
      chk("carry8", int'(pc), 10'h100);
      instr_cycle(9'h099, 1'b1, 10'h1FF, 1'b0);
      instr_cycle(9'h0AA, 1'b0, 10'h000, 1'b0);
      chk("carry9", int'(pc), 10'h200);

      // Halt at 0x020, resume at 0x021.
      instr_cycle(9'h0BB, 1'b1, 10'h020, 1'b0);
      instr_cycle(9'h0CC, 1'b0, 10'h000, 1'b1);
      chk("halt pc", int'(pc), 10'h021);
      chk("halt req", int'(imem_req), 0);
      exec_done = 1'b1; step(); exec_done = 1'b0;
      chk("halt hold", int'(pc), 10'h021);
      start = 1'b1; step(); start = 1'b0;
      chk("resume addr", int'(imem_addr), 10'h021);
      chk("resume req", int'(imem_req), 1);
      instr_cycle(9'h0DD, 1'b1, 10'h100, 1'b1);
      chk("halt br pc", int'(pc), 10'h100);
      chk("halt br run", int'(running), 0);

      // Asynchronous reset while fetching at 0x123.
      start = 1'b1; step(); start = 1'b0;
      instr_cycle(9'h0EE, 1'b1, 10'h123, 1'b0);
      chk("pre-rst addr", int'(imem_addr), 10'h123);
      #1 rst_n = 1'b0;
      #1;
      chk("arst req", int'(imem_req), 0);
      chk("arst pc", int'(pc), 0);
      chk("arst run", int'(running), 0);
      imem_ack = 1'b1; imem_data = 9'h1FF; step(); imem_ack = 1'b0;
      rst_n = 1'b1;
      step();
      chk("post pc", int'(pc), 0);
      chk("post instr", int'(instr), 0);
      chk("post run", int'(running), 0);

      step();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
